// File: rtl/wb_pkg.sv
// Shared Wishbone B3 encodings and the line master's state type.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [3:0] SEL_ALL     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clears the byte offset inside a naturally aligned block of 'bytes' bytes.
  function automatic logic [31:0] align_down(input logic [31:0] adr, input int unsigned bytes);
    return adr & ~(bytes - 32'd1);
  endfunction

endpackage

// File: rtl/wb_line_master_if.sv
// Wishbone B3 master-side bus bundle; signal names are from the master's point of view.
interface wb_line_master_if;

  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stb_o;
  logic        cyc_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic        ack_i;

  modport master (
    output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o, cti_o, bte_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, sel_o, stb_o, cyc_o, cti_o, bte_o,
    output dat_i, ack_i
  );

endinterface

// File: rtl/wb_line_master.sv
// Moves one cache line as an incrementing Wishbone burst (fill or writeback).
// Optional watchdog abort when WB_LINE_MASTER_TIMEOUT_EN is defined.
module wb_line_master
  import wb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      req_we_i,
  input  logic [31:0]               req_adr_i,
  input  logic [32*BURST_LEN-1:0]   wr_line_i,
  output logic [32*BURST_LEN-1:0]   rd_line_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  wb_line_master_if.master          wb
);

  localparam int LINE_W     = 32 * BURST_LEN;
  localparam int LINE_BYTES = 4 * BURST_LEN;
  localparam int CNT_W      = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]   beat_nxt;
  logic [LINE_W-1:0]  wr_line_q, wr_line_d;
  logic [LINE_W-1:0]  rd_line_q, rd_line_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [2:0]         cti_q, cti_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

`ifdef WB_LINE_MASTER_TIMEOUT_EN
  logic [15:0]        wd_q, wd_d;
  logic               err_q, err_d;
`endif

  assign beat_nxt = beat_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    wr_line_d = wr_line_q;
    rd_line_d = rd_line_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    cti_d     = cti_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d   = BUS;
          beat_d    = '0;
          wr_line_d = wr_line_i;
          adr_d     = align_down(req_adr_i, LINE_BYTES);
          dat_d     = wr_line_i[31:0];
          we_d      = req_we_i;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          sel_d     = SEL_ALL;
          cti_d     = CTI_INCR;
          busy_d    = 1'b1;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
          wd_d      = '0;
`endif
        end
      end

      BUS: begin
        if (wb.ack_i) begin
          if (!we_q) begin
            rd_line_d[32*int'(beat_q) +: 32] = wb.dat_i;
          end
`ifdef WB_LINE_MASTER_TIMEOUT_EN
          wd_d = '0;
`endif
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            beat_d  = '0;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = '0;
            cti_d   = CTI_CLASSIC;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_nxt;
            adr_d  = adr_q + 32'd4;
            dat_d  = wr_line_q[32*int'(beat_nxt) +: 32];
            cti_d  = (beat_nxt == LAST_BEAT) ? CTI_EOB : CTI_INCR;
          end
        end
`ifdef WB_LINE_MASTER_TIMEOUT_EN
        // Abort on the edge that would take the idle count to 16'hFFFF.
        else if (wd_q == 16'hFFFE) begin
          state_d = IDLE;
          beat_d  = '0;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          cti_d   = CTI_CLASSIC;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      wr_line_q <= '0;
      rd_line_q <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      cti_q     <= CTI_CLASSIC;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      wr_line_q <= wr_line_d;
      rd_line_q <= rd_line_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      cti_q     <= cti_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef WB_LINE_MASTER_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign rd_line_o = rd_line_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign wb.adr_o  = adr_q;
  assign wb.dat_o  = dat_q;
  assign wb.we_o   = we_q;
  assign wb.sel_o  = sel_q;
  assign wb.stb_o  = stb_q;
  assign wb.cyc_o  = cyc_q;
  assign wb.cti_o  = cti_q;
  assign wb.bte_o  = BTE_LINEAR;

endmodule

// File: tb/tb_wb_line_master.sv
// Directed + randomized bench for wb_line_master against a line-level memory model.
module tb_wb_line_master;

  localparam int BL = 4;
  localparam int LW = 32 * BL;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [3:0]  sel;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_i = 1'b0;
  logic          req_we_i = 1'b0;
  logic [31:0]   req_adr_i = '0;
  logic [LW-1:0] wr_line_i = '0;
  logic [LW-1:0] rd_line_o;
  logic          busy_o, done_o, err_o;

  wb_line_master_if wb();

  wb_line_master #(.BURST_LEN(BL)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .req_we_i  (req_we_i),
    .req_adr_i (req_adr_i),
    .wr_line_i (wr_line_i),
    .rd_line_o (rd_line_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .wb        (wb)
  );

  always #5 clk_i = ~clk_i;

  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  bit    err_seen = 1'b0;
  bit    loaded = 1'b0;
  bit    ack_en = 1'b1;
  int    wait_mode = 0;
  int    wait_cnt = 0;
  logic [31:0] mem [0:1023];
  beat_t beats[$];

  // Slave: registered ack, combinational read data, writes on acknowledged beats.
  assign wb.dat_i = mem[wb.adr_o[11:2]];

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb.ack_i <= 1'b0;
      wait_cnt <= 0;
      if (!loaded) begin
        for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
        mem[64] <= 32'h11223344;
        mem[65] <= 32'h55667788;
        mem[66] <= 32'h99AABBCC;
        mem[67] <= 32'hDDEEFF00;
        loaded <= 1'b1;
      end
    end else begin
      if (wb.ack_i && wb.cyc_o && wb.stb_o) begin
        beats.push_back('{adr: wb.adr_o, cti: wb.cti_o, we: wb.we_o, sel: wb.sel_o});
        if (wb.we_o) mem[wb.adr_o[11:2]] <= wb.dat_o;
      end
      if (ack_en && wb.cyc_o && wb.stb_o && wait_cnt == 0) begin
        wb.ack_i <= 1'b1;
        wait_cnt <= (wait_mode == 1) ? 2 : (wait_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      end else begin
        wb.ack_i <= 1'b0;
        if (wait_cnt != 0) wait_cnt <= wait_cnt - 1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    if (err_o !== 1'b0) err_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One line transfer; expectations come from the line rules and the memory image.
  task automatic do_line(input logic we, input logic [31:0] adr, input logic [LW-1:0] wl, input bit poke);
    logic [31:0]   base;
    logic [LW-1:0] exp_rd;
    int            n, b0, d0;
    bit            sel_bad;
    base = adr & ~32'(BL * 4 - 1);
    for (int k = 0; k < BL; k++) exp_rd[32*k +: 32] = mem[(base[11:2] + 10'(k))];
    b0 = beats.size();
    d0 = done_cnt;
    @(negedge clk_i);
    req_i = 1'b1; req_we_i = we; req_adr_i = adr; wr_line_i = wl;
    @(negedge clk_i);
    req_i = 1'b0;
    chk("busy_at_bus_entry", busy_o, 1);
    chk("first_adr", wb.adr_o, base);
    chk("first_cti", wb.cti_o, 3'b010);
    n = 0;
    sel_bad = 1'b0;
    while (done_o !== 1'b1 && n < 400) begin
      if (wb.cyc_o && wb.sel_o !== 4'hF) sel_bad = 1'b1;
      if (poke && n == 1) begin
        req_i = 1'b1; req_adr_i = ~adr; wr_line_i = ~wl; req_we_i = ~we;
      end
      if (poke && n == 2) req_i = 1'b0;
      @(negedge clk_i);
      n++;
    end
    chk("done_seen", done_o, 1);
    if (wait_mode == 0) chk("burst_cycles", n, BL + 1);
    chk("busy_in_done", busy_o, 0);
    chk("cyc_in_done", wb.cyc_o, 0);
    chk("stb_in_done", wb.stb_o, 0);
    chk("we_in_done", wb.we_o, 0);
    chk("sel_during_cycle", sel_bad, 0);
    chk("beat_count", beats.size() - b0, BL);
    for (int k = 0; k < BL && b0 + k < beats.size(); k++) begin
      chk("beat_adr", beats[b0+k].adr, base + 32'(4 * k));
      chk("beat_cti", beats[b0+k].cti, (k == BL - 1) ? 3'b111 : 3'b010);
      chk("beat_we", beats[b0+k].we, we);
    end
    if (!we) chk("fill_line", rd_line_o, exp_rd);
    else for (int k = 0; k < BL; k++) chk("wb_mem_word", mem[(base[11:2] + 10'(k))], wl[32*k +: 32]);
    if (poke) begin
      req_i = 1'b1;
      @(negedge clk_i);
      req_i = 1'b0;
      chk("req_in_done_ignored", wb.cyc_o, 0);
      @(negedge clk_i);
      chk("no_requeue", busy_o, 0);
    end else begin
      @(negedge clk_i);
    end
    chk("done_one_cycle", done_o, 0);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    logic [LW-1:0] wl;
    int n, b0;

    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_cyc", wb.cyc_o, 0);
    chk("rst_stb", wb.stb_o, 0);
    chk("rst_we", wb.we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_adr", wb.adr_o, 0);
    chk("rst_dat", wb.dat_o, 0);
    chk("rst_rd_line", rd_line_o, 0);
    chk("rst_sel", wb.sel_o, 0);
    chk("rst_cti", wb.cti_o, 3'b000);
    chk("bte_linear", wb.bte_o, 2'b00);
    rst_i = 1'b0;
    @(negedge clk_i);

    do_line(1'b0, 32'h0000_0100, '0, 1'b0);
    chk("fill_0x100_const", rd_line_o, {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344});

    wl = {$urandom, $urandom, $urandom, $urandom};
    do_line(1'b1, 32'h0000_0217, wl, 1'b0);

    wait_mode = 1;
    do_line(1'b0, $urandom, '0, 1'b0);
    do_line(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    wait_mode = 0;
    do_line(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    do_line(1'b0, $urandom, '0, 1'b0);

    wait_mode = 2;
    for (int t = 0; t < 6; t++)
      do_line(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_mode = 0;
    do_line(1'b0, 32'hFFFF_FFF8, '0, 1'b0);

    // Asynchronous reset while beat 2 of a fill is on the bus.
    b0 = beats.size();
    @(negedge clk_i);
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h0000_0340;
    @(negedge clk_i);
    req_i = 1'b0;
    n = 0;
    while (beats.size() - b0 < 2 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("reached_beat2", beats.size() - b0, 2);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_cyc", wb.cyc_o, 0);
    chk("arst_stb", wb.stb_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_rd_line", rd_line_o, 0);
    chk("arst_adr", wb.adr_o, 0);
    chk("arst_cti", wb.cti_o, 3'b000);
    @(negedge clk_i);
    rst_i = 1'b0;
    do_line(1'b0, 32'h0000_0344, '0, 1'b0);

`ifdef WB_LINE_MASTER_TIMEOUT_EN
    ack_en = 1'b0;
    b0 = done_cnt;
    @(negedge clk_i);
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h0000_0400;
    @(negedge clk_i);
    req_i = 1'b0;
    n = 0;
    while (err_o !== 1'b1 && n < 70000) begin
      @(negedge clk_i);
      n++;
    end
    chk("timeout_cycles", n, 65535);
    chk("timeout_cyc_low", wb.cyc_o, 0);
    chk("timeout_no_done", done_cnt - b0, 0);
    @(negedge clk_i);
    chk("err_one_cycle", err_o, 0);
    ack_en = 1'b1;
    do_line(1'b0, 32'h0000_0400, '0, 1'b0);
`else
    chk("err_never", err_seen, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
